imm_extend_pipe: RTL

//  Registered, flow-controlled immediate generator for the decode stage.

---
 rtl/imm_extend_pipe_pkg.sv | 22 ++
 rtl/imm_extend_pipe_decode.sv | 45 ++++
 rtl/imm_extend_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Imm_pkg: ImmSrc selector encoding shared by the immediate generator.
// Rev 1.0
//------------------------------------------------------------------------------
package Imm_pkg;

  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_TypeI    = 3'd0,
    IMM_TypeS    = 3'd1,
    IMM_TypeB    = 3'd2,
    IMM_TypeU    = 3'd3,
    IMM_TypeJ    = 3'd4,
    IMM_TypeZ    = 3'd5,
    IMM_TypeSH   = 3'd6,
    IMM_Reserved = 3'd7
  } imm_src_e;

endpackage
`default_nettype wire

// File: rtl/imm_extend_pipe_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// imm_decode: combinational immediate extraction and extension to XLEN bits.
// Rev 1.0
//------------------------------------------------------------------------------
module imm_decode
  import Imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_src_e        src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [63:0] sign;
  logic [63:0] imm_wide;
  logic        unused_bits;

  // Build everything at 64 bits and truncate, so XLEN=32 needs no zero-width fills.
  assign sign = {64{instr[31]}};

  always_comb begin
    imm_wide = '0;
    err      = 1'b0;
    case (src)
      IMM_TypeI:  imm_wide = {sign[63:12], instr[31:20]};
      IMM_TypeS:  imm_wide = {sign[63:12], instr[31:25], instr[11:7]};
      IMM_TypeB:  imm_wide = {sign[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_TypeU:  imm_wide = {sign[63:32], instr[31:12], 12'b0};
      IMM_TypeJ:  imm_wide = {sign[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_TypeZ:  imm_wide = {59'b0, instr[19:15]};
      IMM_TypeSH: imm_wide = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      default:    err      = 1'b1;
    endcase
  end

  assign imm = imm_wide[XLEN-1:0];

  // Opcode bits never feed an immediate; upper bits are dropped when XLEN=32.
  assign unused_bits = ^{instr[6:0], imm_wide};

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// imm_extend_pipe: immediate generator feeding a DEPTH-entry valid/ready FIFO.
// Rev 1.0
//------------------------------------------------------------------------------
module imm_extend_pipe
  import Imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_src,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_err [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr (in_instr),
    .src   (imm_src_e'(in_src)),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A same-cycle pop frees the slot a full FIFO would otherwise refuse.
  assign in_ready  = !rst & !flush & ((count < DEPTH_CNT) | pop);
  assign push      = in_valid & in_ready;

  assign out_imm = mem_imm[rd_ptr];
  assign out_tag = mem_tag[rd_ptr];
  assign out_err = mem_err[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
        mem_err[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_tag[wr_ptr] <= in_tag;
        mem_err[wr_ptr] <= dec_err;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
